// File: rtl/gray_decoder_counter.sv
// Gray-code position tracker: decodes a 4-bit reflected Gray input, classifies each change as an
// up step, down step or illegal jump, and keeps a position and a saturating error count.
// Define GRAY_SYNC_EN to put a two-flop synchronizer in front of the decoder (default: one register).
module gray_decoder_counter #(
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       gray_in,
    output logic [3:0]       binary_out,
    output logic             step_up,
    output logic             step_down,
    output logic             step_err,
    output logic [7:0]       position,
    output logic [ERR_W-1:0] err_count,
    output logic             valid
);
    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_e;

    // The vld flag travels with the sample so the tracker never treats cleared flops as a real reading.
    logic [3:0] sync_q;
    logic       sync_vld_q;

`ifdef GRAY_SYNC_EN
    logic [3:0] meta_q;
    logic       meta_vld_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q     <= 4'd0;
            meta_vld_q <= 1'b0;
            sync_q     <= 4'd0;
            sync_vld_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, which is what lets this chain act as a two-stage shift.
            meta_q     <= gray_in;
            meta_vld_q <= 1'b1;
            sync_q     <= meta_q;
            sync_vld_q <= meta_vld_q;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q     <= 4'd0;
            sync_vld_q <= 1'b0;
        end else begin
            sync_q     <= gray_in;
            sync_vld_q <= 1'b1;
        end
    end
`endif

    state_e           state_q;
    logic [3:0]       binary_out_q;
    logic             step_up_q;
    logic             step_down_q;
    logic             step_err_q;
    logic [7:0]       position_q;
    logic [ERR_W-1:0] err_count_q;
    logic             valid_q;

    logic [3:0] decoded;
    logic [3:0] delta;

    always_comb begin
        decoded[3] = sync_q[3];
        decoded[2] = sync_q[3] ^ sync_q[2];
        decoded[1] = sync_q[3] ^ sync_q[2] ^ sync_q[1];
        decoded[0] = sync_q[3] ^ sync_q[2] ^ sync_q[1] ^ sync_q[0];
        // 4-bit subtraction wraps, so 15->0 gives 1 and 0->15 gives 15.
        delta      = decoded - binary_out_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_INIT;
            binary_out_q <= 4'd0;
            step_up_q    <= 1'b0;
            step_down_q  <= 1'b0;
            step_err_q   <= 1'b0;
            position_q   <= 8'd0;
            err_count_q  <= '0;
            valid_q      <= 1'b0;
        end else begin
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            step_err_q  <= 1'b0;
            if (enable && sync_vld_q) begin
                case (state_q)
                    ST_INIT: begin
                        binary_out_q <= decoded;
                        valid_q      <= 1'b1;
                        state_q      <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (delta == 4'd1) begin
                            step_up_q    <= 1'b1;
                            position_q   <= position_q + 8'd1;
                            binary_out_q <= decoded;
                        end else if (delta == 4'd15) begin
                            step_down_q  <= 1'b1;
                            position_q   <= position_q - 8'd1;
                            binary_out_q <= decoded;
                        end else if (delta != 4'd0) begin
                            step_err_q   <= 1'b1;
                            binary_out_q <= decoded;
                            if (err_count_q != '1) begin
                                err_count_q <= err_count_q + ERR_W'(1);
                            end
                        end
                    end
                    default: state_q <= ST_INIT;
                endcase
            end
        end
    end

    assign binary_out = binary_out_q;
    assign step_up    = step_up_q;
    assign step_down  = step_down_q;
    assign step_err   = step_err_q;
    assign position   = position_q;
    assign err_count  = err_count_q;
    assign valid      = valid_q;

endmodule
